pixel_color_fifo: RTL
=====================

# pixel_color_fifo

Elastic colour buffer directly downstream of the shader pipeline. It absorbs the bursty `color_valid` RGB stream from the shader and delivers one pixel per display pop to the HDMI timing/encoder stage. It also provides fill-level back-pressure for the upstream coordinate issuer, plus underflow/overflow statistics for bring-up.

## Interface
Parameters:
- `DEPTH`, 64: number of 24-bit entries; must be a power of two.
- `ADDR_WIDTH`, 6: log2(DEPTH).
- `PRIME_LEVEL`, 16: fill level required before popping from storage begins.
- `ALMOST_FULL_THRESH`, 56: `almost_full` asserts when level ≥ this value.
- `UNDERFLOW_COLOR`, 24'h000000: RGB substituted when no data is available.

Ports:
- `clk`  in  1: single clock for all logic.
- `rst_n`  in  1: asynchronous, active-low reset.
- `red_in`/`green_in`/`blue_in`  in  8 each: shader colour.
- `color_valid`  in  1: push strobe, one pixel per high cycle.
- `frame_start`  in  1: one-cycle flush pulse issued at the top of each frame.
- `pop`  in  1: display requests the next pixel (active-video cycle).
- `clr_stats`  in  1: clears the counters and the sticky flag.
- `red_out`/`green_out`/`blue_out`  out  8 each: registered pixel output.
- `out_valid`  out  1: high the cycle after each `pop`.
- `full`, `empty`, `almost_full`  out  1: registered status flags.
- `level`  out  ADDR_WIDTH+1: current occupancy, 0..DEPTH.
- `underflow_count`, `overflow_count`  out  16: saturating counters.
- `underflow_sticky`  out  1: set on the first underflow.

## Operation
- Storage is a DEPTH×24 RAM with rd/wr pointers of ADDR_WIDTH bits that wrap modulo DEPTH. `level` is tracked as a separate counter.
- Push is accepted when `color_valid && (!full || pop_accepted)`.
  - A push while full with no accepted pop is dropped, and `overflow_count` increments.
- Read state machine has two states, PRIME and RUN.
  - **PRIME** (reset and post-flush state): a `pop` does not read storage. It returns `UNDERFLOW_COLOR`, is not counted, and does not move `rd_ptr`. Transition to RUN when `level ≥ PRIME_LEVEL`, evaluated on the registered level.
  - **RUN**: a `pop` with `!empty` returns the head entry and advances `rd_ptr`. A `pop` with `empty` returns `UNDERFLOW_COLOR`, increments `underflow_count` and sets `underflow_sticky`. The block stays in RUN until flushed.
- `pop_accepted` = RUN && `pop` && !`empty`.
- Level update: +1 on an accepted push only, −1 on an accepted pop only, unchanged when both or neither occur.
- Simultaneous push and pop:
  - When empty in RUN: the pop underflows and the push is stored.
  - When full: both proceed, and the level stays at DEPTH.
- `frame_start` has priority over push and pop in the same cycle.
  - Pointers and level go to 0 and state goes to PRIME.
  - A coincident push is discarded and is not counted as overflow.
  - A coincident pop returns `UNDERFLOW_COLOR` and is not counted.
  - Counters and the sticky flag are unaffected.
- `clr_stats` zeroes both counters and the sticky flag. If it coincides with an event, clear wins and the event is not counted.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - RGB outputs = 0, `out_valid` = 0, `full` = 0, `empty` = 1, `almost_full` = 0.
  - `level` = 0, both counters = 0, `underflow_sticky` = 0, state = PRIME, pointers = 0.
- Pop to data latency is 1 cycle: a `pop` in cycle N gives registered RGB and `out_valid` = 1 in cycle N+1. With `pop` = 0, RGB holds its last value and `out_valid` = 0.
- Push to visibility: data written in cycle N is poppable from cycle N+1, because `empty` is deasserted in N+1.
- Flags and `level` are registered and reflect all accepted operations of the previous cycle.
- PRIME→RUN takes effect the cycle after `level` reaches `PRIME_LEVEL`; the first storage read can occur in that cycle.
- A reset asserted mid-operation returns every output to its reset value immediately, with no clock needed. Stored RAM contents are don't-care.

## Test plan
- **Reset then prime:** after reset, push 16 pixels (0x010101..0x101010) while popping continuously.
  - Pops before RUN return 0x000000 with `underflow_count` = 0.
  - After the transition, pops return 0x010101, 0x020202, … in order.
- **Fill to full:** push 64 with no pop, giving `full` = 1, `level` = 64, and `almost_full` asserted from level 56. The 65th push is dropped: `overflow_count` = 1 and contents are unchanged.
- **Full with push and pop in the same cycle:** the push is accepted, `level` stays 64, `overflow_count` is unchanged, and the popped data is the oldest entry.
- **Underflow in RUN:** drain to empty and pop 3 more times. Output is 0x000000 three times, `underflow_count` = 3, `underflow_sticky` = 1. A `clr_stats` pulse then returns both to 0.
- **Flush mid-stream:** `frame_start` with level 20 and coincident push/pop.
  - Next cycle: `level` = 0, `empty` = 1, state PRIME.
  - The popped output is 0x000000 and neither counter changes.
- **Pointer wrap:** stream 1000 incrementing pixels with a 1:1 push/pop ratio after priming. Output equals the input sequence exactly with no loss, and both counters stay 0.

Source files
------------

// File: rtl/pixel_color_fifo.sv
// Elastic RGB buffer between the shader pipeline and the HDMI encoder.
// Primes to a fill level before serving pops, then streams one pixel per pop.
module pixel_color_fifo #(
  parameter int          DEPTH              = 64,
  parameter int          ADDR_WIDTH         = 6,
  parameter int          PRIME_LEVEL        = 16,
  parameter int          ALMOST_FULL_THRESH = 56,
  parameter logic [23:0] UNDERFLOW_COLOR    = 24'h000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            red_in,
  input  logic [7:0]            green_in,
  input  logic [7:0]            blue_in,
  input  logic                  color_valid,
  input  logic                  frame_start,
  input  logic                  pop,
  input  logic                  clr_stats,
  output logic [7:0]            red_out,
  output logic [7:0]            green_out,
  output logic [7:0]            blue_out,
  output logic                  out_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic [15:0]           underflow_count,
  output logic [15:0]           overflow_count,
  output logic                  underflow_sticky
);

  localparam logic [ADDR_WIDTH:0]   LVL_ONE   = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_LVL = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   PRIME_LVL = PRIME_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AF_LVL    = ALMOST_FULL_THRESH[ADDR_WIDTH:0];

  typedef enum logic {PRIME, RUN} state_t;

  state_t                state;
  logic [23:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   level_next;
  logic                  pop_accepted;
  logic                  push_accepted;
  logic                  overflow_evt;
  logic                  underflow_evt;

  // A flush pulse masks every push/pop event in its cycle.
  always_comb begin
    pop_accepted  = (state == RUN) && pop && !empty && !frame_start;
    push_accepted = color_valid && (!full || pop_accepted) && !frame_start;
    overflow_evt  = color_valid && full && !pop_accepted && !frame_start;
    underflow_evt = (state == RUN) && pop && empty && !frame_start;
  end

  always_comb begin
    level_next = level;
    if (frame_start)
      level_next = '0;
    else if (push_accepted && !pop_accepted)
      level_next = level + LVL_ONE;
    else if (!push_accepted && pop_accepted)
      level_next = level - LVL_ONE;
  end

  always_ff @(posedge clk) begin
    if (push_accepted)
      mem[wr_ptr] <= {red_in, green_in, blue_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PRIME;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      level       <= level_next;
      empty       <= (level_next == '0);
      full        <= (level_next == DEPTH_LVL);
      almost_full <= (level_next >= AF_LVL);
      if (frame_start) begin
        state  <= PRIME;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (state == PRIME && level >= PRIME_LVL)
          state <= RUN;
        if (push_accepted)
          wr_ptr <= wr_ptr + PTR_ONE;
        if (pop_accepted)
          rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Read data reflects the RAM before any same-cycle write, so a full
  // push+pop returns the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {red_out, green_out, blue_out} <= 24'h000000;
      out_valid                      <= 1'b0;
    end else begin
      out_valid <= pop;
      if (pop) begin
        if (pop_accepted)
          {red_out, green_out, blue_out} <= mem[rd_ptr];
        else
          {red_out, green_out, blue_out} <= UNDERFLOW_COLOR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_count  <= '0;
      overflow_count   <= '0;
      underflow_sticky <= 1'b0;
    end else if (clr_stats) begin
      underflow_count  <= '0;
      overflow_count   <= '0;
      underflow_sticky <= 1'b0;
    end else begin
      if (overflow_evt && overflow_count != 16'hFFFF)
        overflow_count <= overflow_count + 16'd1;
      if (underflow_evt && underflow_count != 16'hFFFF)
        underflow_count <= underflow_count + 16'd1;
      if (underflow_evt)
        underflow_sticky <= 1'b1;
    end
  end

endmodule
